// File: rtl/router_2_out_arbiter.sv
// router_2_out_arbiter: per-output-port round-robin arbiter for router_2.
// Locks the output to one input (N/E/L) from header to tail flit, drives the
// crossbar select and the per-input grants that pop the input FIFOs.
// Optional feature macro: ARB_TIMEOUT_EN (adds stall counter + timeout port).

`ifndef N_PORT
`define N_PORT 3'd0
`endif
`ifndef E_PORT
`define E_PORT 3'd1
`endif
`ifndef L_PORT
`define L_PORT 3'd4
`endif

module router_2_out_arbiter #(
  parameter logic [2:0] SEL_IDLE = 3'b111
`ifdef ARB_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = 16
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       N_req,
  input  logic       E_req,
  input  logic       L_req,
  input  logic       N_tail,
  input  logic       E_tail,
  input  logic       L_tail,
  input  logic       out_ready,
  output logic       N_gnt,
  output logic       E_gnt,
  output logic       L_gnt,
  output logic [2:0] sel_out,
  output logic       busy
`ifdef ARB_TIMEOUT_EN
  , output logic     timeout
`endif
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t     state_reg, state_next;
  logic [1:0] owner_reg, owner_next;
  logic [1:0] ptr_reg, ptr_next;

  logic [2:0] req_vec;
  logic [2:0] gnt_vec;
  logic [1:0] ptr_eff;
  logic [1:0] cand [3];
  logic [1:0] pick_idx;
  logic       pick_valid;
  logic       req_owner;
  logic       tail_owner;
  logic       transfer;
  logic [2:0] owner_code;

  // Index after idx in N -> E -> L -> N order
  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    case (idx)
      2'd0:    next_idx = 2'd1;
      2'd1:    next_idx = 2'd2;
      default: next_idx = 2'd0;
    endcase
  endfunction

  assign req_vec = {L_req, E_req, N_req};

  // A pointer of 3 can never be loaded; should it appear, N gets priority
  assign ptr_eff = (ptr_reg == 2'd3) ? 2'd0 : ptr_reg;

  // Candidate order: ptr, ptr+1, ptr+2 (mod 3)
  assign cand[0] = ptr_eff;
  assign cand[1] = next_idx(ptr_eff);
  assign cand[2] = next_idx(next_idx(ptr_eff));

  // Round-robin pick: scan lowest priority first so the highest one wins
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = ptr_eff;
    for (int k = 2; k >= 0; k--) begin
      if (req_vec[cand[k]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[k];
      end
    end
  end

  // Request, tail and crossbar code of the current owner
  always_comb begin
    req_owner  = 1'b0;
    tail_owner = 1'b0;
    owner_code = SEL_IDLE;
    case (owner_reg)
      2'd0: begin
        req_owner  = N_req;
        tail_owner = N_tail;
        owner_code = `N_PORT;
      end
      2'd1: begin
        req_owner  = E_req;
        tail_owner = E_tail;
        owner_code = `E_PORT;
      end
      2'd2: begin
        req_owner  = L_req;
        tail_owner = L_tail;
        owner_code = `L_PORT;
      end
      default: begin
        req_owner  = 1'b0;
        tail_owner = 1'b0;
        owner_code = SEL_IDLE;
      end
    endcase
  end

  // A flit moves only while locked, owner has a flit and downstream has credit;
  // nothing is granted while reset is held
  assign transfer = rst && (state_reg == LOCKED) && req_owner && out_ready;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_gnt
      assign gnt_vec[gi] = transfer && (owner_reg == 2'(gi));
    end
  endgenerate

  assign N_gnt   = gnt_vec[0];
  assign E_gnt   = gnt_vec[1];
  assign L_gnt   = gnt_vec[2];
  assign sel_out = transfer ? owner_code : SEL_IDLE;
  assign busy    = rst && (state_reg == LOCKED);

`ifdef ARB_TIMEOUT_EN
  logic [4:0] stall_cnt_reg, stall_cnt_next;
  logic       timeout_hit;

  // The stall that brings the count to TIMEOUT_CYC is the releasing cycle
  assign timeout_hit = rst && (state_reg == LOCKED) && !req_owner &&
                       (stall_cnt_reg == 5'(TIMEOUT_CYC - 1));
  assign timeout     = timeout_hit;

  // Count consecutive locked cycles where the owner has no flit
  always_comb begin
    stall_cnt_next = 5'd0;
    if ((state_reg == LOCKED) && !req_owner && !timeout_hit) begin
      stall_cnt_next = stall_cnt_reg + 5'd1;
    end
  end

  // Stall counter register
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_reg <= 5'd0;
    end else begin
      stall_cnt_reg <= stall_cnt_next;
    end
  end
`endif

  // Next-state logic: arbitrate in IDLE, release on a transferred tail
  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          owner_next = pick_idx;
          state_next = LOCKED;
        end
      end
      LOCKED: begin
        if (transfer && tail_owner) begin
          state_next = IDLE;
          ptr_next   = next_idx(owner_reg);
        end
`ifdef ARB_TIMEOUT_EN
        else if (timeout_hit) begin
          state_next = IDLE;
          ptr_next   = next_idx(owner_reg);
        end
`endif
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, owner and pointer registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      owner_reg <= 2'd0;
      ptr_reg   <= 2'd0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      ptr_reg   <= ptr_next;
    end
  end

endmodule

// File: tb/tb_router_2_out_arbiter.sv
// Directed testbench for router_2_out_arbiter.
// Observed vector per cycle: {L_gnt, E_gnt, N_gnt, sel_out, busy}.

`ifndef N_PORT
`define N_PORT 3'd0
`endif
`ifndef E_PORT
`define E_PORT 3'd1
`endif
`ifndef L_PORT
`define L_PORT 3'd4
`endif

module tb_router_2_out_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       N_req, E_req, L_req;
  logic       N_tail, E_tail, L_tail;
  logic       out_ready;
  logic       N_gnt, E_gnt, L_gnt;
  logic [2:0] sel_out;
  logic       busy;
`ifdef ARB_TIMEOUT_EN
  logic       timeout;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] V_IDLE  = {3'b000, 3'b111, 1'b0};
  localparam logic [6:0] V_STALL = {3'b000, 3'b111, 1'b1};
  localparam logic [6:0] V_N     = {3'b001, `N_PORT, 1'b1};
  localparam logic [6:0] V_E     = {3'b010, `E_PORT, 1'b1};
  localparam logic [6:0] V_L     = {3'b100, `L_PORT, 1'b1};

  logic [6:0] obs;
  assign obs = {L_gnt, E_gnt, N_gnt, sel_out, busy};

  always #5 clk = ~clk;

  router_2_out_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .N_req     (N_req),
    .E_req     (E_req),
    .L_req     (L_req),
    .N_tail    (N_tail),
    .E_tail    (E_tail),
    .L_tail    (L_tail),
    .out_ready (out_ready),
    .N_gnt     (N_gnt),
    .E_gnt     (E_gnt),
    .L_gnt     (L_gnt),
    .sel_out   (sel_out),
    .busy      (busy)
`ifdef ARB_TIMEOUT_EN
    , .timeout (timeout)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic n, input logic e, input logic l,
                         input logic nt, input logic et, input logic lt);
    N_req  = n;
    E_req  = e;
    L_req  = l;
    N_tail = nt;
    E_tail = et;
    L_tail = lt;
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    out_ready = 1'b1;
    set_req(0, 0, 0, 0, 0, 0);
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    out_ready = 1'b1;
    set_req(1, 1, 1, 1, 1, 1);
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      $display("[%0t] reset cycle %0d: obs=%b", $time, i, obs);
      if (obs !== V_IDLE) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: got %b expected %b", i, obs, V_IDLE);
      end
      step();
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    $display("[%0t] reset release bubble: obs=%b", $time, obs);
    if (obs !== V_IDLE) begin
      errors++;
      $display("FAIL reset_bubble: got %b expected %b", obs, V_IDLE);
    end
    step();
    @(negedge clk);
    checks++;
    $display("[%0t] reset first grant: obs=%b", $time, obs);
    if (obs !== V_N) begin
      errors++;
      $display("FAIL reset_first_grant: got %b expected %b", obs, V_N);
    end
    step();
  endtask

  task automatic test_fairness();
    logic [6:0] ev [12];
    ev = '{V_IDLE, V_N, V_IDLE, V_E, V_IDLE, V_L,
           V_IDLE, V_N, V_IDLE, V_E, V_IDLE, V_L};
    do_reset();
    set_req(1, 1, 1, 1, 1, 1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      $display("[%0t] fairness cycle %0d: obs=%b", $time, i, obs);
      if (obs !== ev[i]) begin
        errors++;
        $display("FAIL fairness cycle %0d: got %b expected %b", i, obs, ev[i]);
      end
      step();
    end
    set_req(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_multi_flit();
    logic [6:0] ev [7];
    ev = '{V_IDLE, V_E, V_E, V_E, V_E, V_IDLE, V_N};
    do_reset();
    set_req(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      if (i == 1) begin
        N_req  = 1'b1;
        N_tail = 1'b1;
      end
      if (i == 4) E_tail = 1'b1;
      if (i == 5) begin
        E_req  = 1'b0;
        E_tail = 1'b0;
      end
      @(negedge clk);
      checks++;
      $display("[%0t] multi_flit cycle %0d: obs=%b", $time, i, obs);
      if (obs !== ev[i]) begin
        errors++;
        $display("FAIL multi_flit cycle %0d: got %b expected %b", i, obs, ev[i]);
      end
      step();
    end
    set_req(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_backpressure();
    logic [6:0] ev [12];
    logic [11:0] rdy, lreq, ltail, nreq;
    ev    = '{V_IDLE, V_L, V_STALL, V_STALL, V_STALL, V_L,
              V_STALL, V_L, V_STALL, V_L, V_IDLE, V_N};
    // bit i = value in cycle i
    rdy   = 12'b1110_1110_0011;
    lreq  = 12'b0011_1011_1111;
    ltail = 12'b0011_0000_0000;
    nreq  = 12'b1111_1111_1100;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      out_ready = rdy[i];
      set_req(nreq[i], 1'b0, lreq[i], 1'b1, 1'b0, ltail[i]);
      @(negedge clk);
      checks++;
      $display("[%0t] backpressure cycle %0d: obs=%b", $time, i, obs);
      if (obs !== ev[i]) begin
        errors++;
        $display("FAIL backpressure cycle %0d: got %b expected %b", i, obs, ev[i]);
      end
      step();
    end
    out_ready = 1'b1;
    set_req(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid_packet();
    logic [6:0] ev [4];
    ev = '{V_IDLE, V_E, V_IDLE, V_N};
    do_reset();
    set_req(0, 1, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) set_req(1, 0, 0, 0, 0, 0);
      @(negedge clk);
      checks++;
      $display("[%0t] reset_mid setup cycle %0d: obs=%b", $time, i, obs);
      if (obs !== ev[i]) begin
        errors++;
        $display("FAIL reset_mid_setup cycle %0d: got %b expected %b", i, obs, ev[i]);
      end
      step();
    end
    // Flit 2 of the N packet: reset lands here
    rst = 1'b0;
    step();
    rst = 1'b1;
    set_req(1, 1, 1, 1, 1, 1);
    @(negedge clk);
    checks++;
    $display("[%0t] reset_mid after reset: obs=%b", $time, obs);
    if (obs !== V_IDLE) begin
      errors++;
      $display("FAIL reset_mid_idle: got %b expected %b", obs, V_IDLE);
    end
    step();
    @(negedge clk);
    checks++;
    $display("[%0t] reset_mid regrant: obs=%b", $time, obs);
    if (obs !== V_N) begin
      errors++;
      $display("FAIL reset_mid_ptr: got %b expected %b", obs, V_N);
    end
    step();
    set_req(0, 0, 0, 0, 0, 0);
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    set_req(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if ({obs, timeout} !== {V_IDLE, 1'b0}) begin
      errors++;
      $display("FAIL timeout_bubble: got %b/%b expected %b/0", obs, timeout, V_IDLE);
    end
    step();
    @(negedge clk);
    checks++;
    $display("[%0t] timeout header: obs=%b", $time, obs);
    if ({obs, timeout} !== {V_N, 1'b0}) begin
      errors++;
      $display("FAIL timeout_header: got %b/%b expected %b/0", obs, timeout, V_N);
    end
    step();
    set_req(0, 1, 0, 0, 1, 0);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      checks++;
      $display("[%0t] timeout stall %0d: obs=%b timeout=%b", $time, k, obs, timeout);
      if ({obs, timeout} !== {V_STALL, (k == 16)}) begin
        errors++;
        $display("FAIL timeout_stall %0d: got %b/%b expected %b/%b",
                 k, obs, timeout, V_STALL, (k == 16));
      end
      step();
    end
    @(negedge clk);
    checks++;
    if ({obs, timeout} !== {V_IDLE, 1'b0}) begin
      errors++;
      $display("FAIL timeout_release: got %b/%b expected %b/0", obs, timeout, V_IDLE);
    end
    step();
    @(negedge clk);
    checks++;
    $display("[%0t] timeout next grant: obs=%b", $time, obs);
    if ({obs, timeout} !== {V_E, 1'b0}) begin
      errors++;
      $display("FAIL timeout_next_grant: got %b/%b expected %b/0", obs, timeout, V_E);
    end
    step();
    set_req(0, 0, 0, 0, 0, 0);
  endtask
`endif

  initial begin
    rst       = 1'b0;
    out_ready = 1'b1;
    set_req(0, 0, 0, 0, 0, 0);
    test_reset();
    test_fairness();
    test_multi_flit();
    test_backpressure();
    test_reset_mid_packet();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/router_2_out_arbiter.md
Name: router_2_out_arbiter

Overview:
- Per-output-port round-robin arbiter for router_2 of the 2x2 mesh. It sits directly upstream of the output crossbar mux.
- Collects requests from the N, E and L input channels and locks the output to one packet from header flit to tail flit.
- Drives the 3-bit select consumed by the crossbar, plus per-input grants that pop the input FIFOs.
- One instance per output port.

Parameters:
- SEL_IDLE, 3'b111, select value driven when no transfer occurs; differs from every port code, so the crossbar outputs validout=0.
- TIMEOUT_CYC, 16, lock-stall limit in cycles; used only when the optional feature is compiled in.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset; sampled on rising clk edge only.
- N_req  input  1  N input has a flit at FIFO head routed to this output.
- E_req  input  1  same, E input.
- L_req  input  1  same, L input.
- N_tail  input  1  flit at N FIFO head is a tail flit; single-flit packets assert both head and tail.
- E_tail  input  1  same, E input.
- L_tail  input  1  same, L input.
- out_ready  input  1  downstream can accept a flit this cycle (credit available).
- N_gnt  output  1  N head flit transferred this cycle; pop N FIFO.
- E_gnt  output  1  same, E input.
- L_gnt  output  1  same, L input.
- sel_out  output  3  `N_PORT / `E_PORT / `L_PORT (router_2 state defines) during a transfer; SEL_IDLE otherwise.
- busy  output  1  output currently locked to a packet.

Behaviour:
- Registered state:
  - state: IDLE or LOCKED.
  - owner: 2-bit index, N=0, E=1, L=2.
  - ptr: round-robin pointer, 2-bit index of highest-priority input.
- Reset (rst=0 at posedge): state=IDLE, owner=0, ptr=0 (N). Outputs during and after reset: all gnt=0, sel_out=SEL_IDLE, busy=0.
- IDLE:
  - If any req is high, pick the first requester scanning ptr, ptr+1, ptr+2 (mod 3).
  - Load owner and go to LOCKED at the next edge.
  - No grant is issued in IDLE, so arbitration costs a 1-cycle bubble.
  - With no requests, stay in IDLE.
- LOCKED:
  - transfer = req[owner] & out_ready.
  - When transfer=1: gnt[owner]=1 and sel_out=code(owner), both combinational in the same cycle.
  - When transfer=0: all gnt=0 and sel_out=SEL_IDLE. This keeps crossbar validout low on stalls and bubbles.
  - Non-owner requests are ignored while LOCKED.
  - When transfer=1 and tail[owner]=1: next state IDLE and ptr <= owner+1 (mod 3, so 2 wraps to 0).
  - Otherwise remain LOCKED with owner unchanged.
- busy = (state==LOCKED).
- At most one gnt is high in any cycle. gnt is never high when out_ready=0.
- Latency:
  - First flit of a packet transfers no earlier than 1 cycle after its req rises (IDLE cycle).
  - Body flits stream at one per cycle while req and out_ready stay high.
  - Back-to-back packets from different inputs have exactly one idle cycle between tail and next header.
- Boundary conditions:
  - Owner req drops mid-packet: hold lock; sel_out=SEL_IDLE until req returns.
  - out_ready=0 on the tail cycle: no release; tail retried.
  - Reset asserted while LOCKED: return to IDLE with ptr=0 on that edge. The partially sent packet is the upstream's responsibility.
  - ptr value 3 is unreachable; if reached, treat it as 0.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With it defined:
  - A 5-bit stall counter increments each LOCKED cycle with req[owner]=0, and clears on any cycle with req[owner]=1 and on leaving LOCKED.
  - When the count reaches TIMEOUT_CYC, force state=IDLE and ptr=owner+1, and pulse an extra output port timeout (1 bit) for one cycle.
- Without it: no counter and no timeout port; the lock persists indefinitely.

Test Plan:
- Reset: hold rst=0 for 3 cycles with all req=1 -> all gnt=0, sel_out=3'b111, busy=0. First grant to N occurs 2 cycles after rst rises.
- Fairness: N, E, L each send a 1-flit packet (req=1, tail=1) continuously with out_ready=1 -> grant order N, E, L, N, E, L, with one idle cycle between grants.
- 4-flit packet from E, tail on the 4th flit, N also requesting -> E_gnt high 4 consecutive cycles, sel_out=`E_PORT each cycle, N not granted until after the bubble.
- Backpressure: out_ready=0 for cycles 2-4 of an L packet -> L_gnt=0 and sel_out=3'b111 during the stall, busy=1, lock kept, streaming resumes on the next ready.
- Reset mid-packet: rst=0 during flit 2 of an N packet -> next cycle state IDLE, ptr=N.
- With ARB_TIMEOUT_EN and TIMEOUT_CYC=16: owner drops req after the header -> timeout pulses on the 16th stall cycle and the next requester is granted.
